// File: rtl/compare_stream_monitor.sv
// Registered exact/wildcard operand comparison stage with valid/ready handshake,
// saturating match statistics and detection of runs of consecutive wildcard matches.
module compare_stream_monitor #(
    parameter int WIDTH   = 3,
    parameter int CW      = 8,
    parameter int RUN_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_dc_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_eq,
    output logic             out_wild_eq,
    output logic             out_run_hit,
    output logic [CW-1:0]    eq_count,
    output logic [CW-1:0]    wild_count,
    output logic [CW-1:0]    total_count
);

    localparam int RW = $clog2(RUN_LEN + 1);

    typedef enum logic [1:0] {IDLE, COUNT, HIT} run_state_t;

    run_state_t    state, state_nxt;
    logic [RW-1:0] run_cnt, run_cnt_nxt;
    logic          hit_nxt;
    logic          accept;
    logic          eq_p0;
    logic          wild_p0;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Stage p0: combinational compare and handshake
    assign in_ready = !clear && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign eq_p0    = (in_a == in_b);
    assign wild_p0  = (((in_a ^ in_b) & ~in_dc_mask) == '0);

    // Once a run has flagged, further matches stay in HIT without re-flagging.
    always_comb begin
        state_nxt   = state;
        run_cnt_nxt = run_cnt;
        hit_nxt     = 1'b0;
        if (accept) begin
            if (!wild_p0) begin
                state_nxt   = IDLE;
                run_cnt_nxt = '0;
            end else if (state != HIT) begin
                run_cnt_nxt = run_cnt + 1'b1;
                if (run_cnt_nxt == RW'(RUN_LEN)) begin
                    state_nxt = HIT;
                    hit_nxt   = 1'b1;
                end else begin
                    state_nxt = COUNT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            run_cnt <= '0;
        end else if (clear) begin
            state   <= IDLE;
            run_cnt <= '0;
        end else begin
            state   <= state_nxt;
            run_cnt <= run_cnt_nxt;
        end
    end

    // Stage p1: registered result and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_eq      <= 1'b0;
            out_wild_eq <= 1'b0;
            out_run_hit <= 1'b0;
            eq_count    <= '0;
            wild_count  <= '0;
            total_count <= '0;
        end else if (clear) begin
            out_valid   <= 1'b0;
            out_eq      <= 1'b0;
            out_wild_eq <= 1'b0;
            out_run_hit <= 1'b0;
            eq_count    <= '0;
            wild_count  <= '0;
            total_count <= '0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_eq      <= eq_p0;
            out_wild_eq <= wild_p0;
            out_run_hit <= hit_nxt;
            eq_count    <= eq_p0   ? sat_inc(eq_count)   : eq_count;
            wild_count  <= wild_p0 ? sat_inc(wild_count) : wild_count;
            total_count <= sat_inc(total_count);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
